seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter N_DIGITS, default 8: number of digit select lines, range 2..16.
REQ-003 Parameter DWELL, default 4: clock cycles each digit is lit, minimum 1.
REQ-004 Parameter BLANK, default 1: all-off cycles between digits, 0 disables blanking.
REQ-005 Parameter ACT_LOW, default 1: 1 makes sel_out and seg_out active-low, 0 makes them active-high.
REQ-006 Port clk, input, 1 bit: rising-edge clock.
REQ-007 Port rst_n, input, 1 bit: synchronous reset, active low.
REQ-008 Port en, input, 1 bit: scan enable.
REQ-009 Port num, input, IDX_W = clog2(N_DIGITS) bits: index of the highest active digit; digits 0..num are scanned.
REQ-010 Port digit_data, input, N_DIGITS*8 bits: segment pattern per digit, digit k in bits [8k+7:8k], 1 = segment on.
REQ-011 Port sel_out, output, N_DIGITS bits: one-hot digit select, polarity set by ACT_LOW.
REQ-012 Port seg_out, output, 8 bits: segment drive for the selected digit, polarity set by ACT_LOW.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-014 The FSM SHALL have three states, IDLE, SHOW and GAP, plus registers idx (IDX_W bits) and tick (dwell/blank counter).
REQ-015 The effective limit SHALL be lim = min(num, N_DIGITS-1), sampled every cycle.
REQ-016 In IDLE with en=1, the next edge SHALL enter SHOW with idx=0, tick=0 and digit 0 data latched.
REQ-017 In SHOW, sel_out SHALL assert only bit idx, and seg_out SHALL drive the pattern latched on SHOW entry; later changes to digit_data SHALL NOT affect the current dwell.
REQ-018 SHOW SHALL last exactly DWELL cycles, then go to GAP if BLANK>0, otherwise directly to SHOW of the next digit.
REQ-019 GAP SHALL last exactly BLANK cycles with sel_out and seg_out all inactive, then go to SHOW of the next digit.
REQ-020 The next digit SHALL be idx+1 if idx<lim, otherwise 0.
REQ-021 If lim drops below the current idx mid-scan, the next digit SHALL be 0.
REQ-022 frame_done SHALL pulse for one cycle on the edge where the next digit wraps to 0.
REQ-023 When lim=0, the block SHALL relight digit 0 every DWELL+BLANK cycles and pulse frame_done at each wrap.
REQ-024 With en=0 in any state, the next edge SHALL go to IDLE: outputs all inactive, idx=0, tick=0, frame_done=0.
REQ-025 When en reasserts, scanning SHALL restart at digit 0.
REQ-026 All outputs SHALL be registered.
REQ-027 At most one sel_out bit SHALL be active in any cycle.

Reset
REQ-028 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, idx=0, tick=0, the latch SHALL clear, sel_out and seg_out SHALL be all inactive (all ones when ACT_LOW=1), and frame_done=0.
REQ-029 Reset SHALL take priority over en.
REQ-030 Reset applied mid-SHOW SHALL blank the outputs on that same edge.

Structure
REQ-031 The state encoding and the ACT_LOW polarity helper function SHALL live in the shared package seg_pkg.
REQ-032 The dwell/blank counter SHALL be one sub-module, scan_tick_cnt, with load, terminal-count and clear functions.
REQ-033 The select and segment polarity SHALL be applied in a single output stage.

Verification
REQ-034 Defaults, num=3, en=1: sel_out cycles FE, FD, FB, F7 with 4 lit cycles and 1 FF cycle each; frame_done pulses every 20 cycles.
REQ-035 num=0: only FE is lit, with period 5 cycles, and frame_done pulses every 5 cycles.
REQ-036 num=7, then num=2 while idx=5: the next lit digit is FE (digit 0), followed by FD and FB.
REQ-037 digit_data[7:0]=0x3F, changed to 0x06 mid-dwell: seg_out holds 0xC0 for the full dwell, and the next visit shows 0xF9.
REQ-038 en dropped mid-SHOW, then reasserted: outputs go FF next cycle, and scanning restarts at FE.
REQ-039 Reset during GAP, plus a BLANK=0 build: outputs and counters return to REQ-028 values, and the BLANK=0 build shows back-to-back digits with no FF cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared FSM encoding and output polarity helper for the segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Active-high drive in, pin-level drive out.
    function automatic logic [15:0] apply_pol(input logic [15:0] v, input bit act_low);
        return act_low ? ~v : v;
    endfunction

endpackage

// File: rtl/scan_tick_cnt.sv
// Dwell/blank cycle counter: clear, load, count up, flag terminal count.
// Latency: cnt registered, tc combinational on cnt. No backpressure.
module scan_tick_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ld_val;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: lights digits 0..num in turn with optional blanking.
// Latency: outputs registered, one edge after state decision. No backpressure; en=0 idles next edge.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int DWELL    = 4,
    parameter int BLANK    = 1,
    parameter int ACT_LOW  = 1,
    localparam int IDX_W   = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [IDX_W-1:0]      num,
    input  logic [N_DIGITS*8-1:0] digit_data,
    output logic [N_DIGITS-1:0]   sel_out,
    output logic [7:0]            seg_out,
    output logic                  frame_done
);

    localparam int TMAX   = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TICK_W = $clog2(TMAX + 1);
    localparam logic [TICK_W-1:0] SHOW_TERM = TICK_W'(DWELL - 1);
    localparam logic [TICK_W-1:0] GAP_TERM  = TICK_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_DIGITS - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    lim;
    logic [IDX_W-1:0]    nxt;
    logic [7:0]          nxt_pat;
    logic [TICK_W-1:0]   tick;
    logic [TICK_W-1:0]   term;
    logic                tc;
    logic                cnt_clr;
    logic                adv;

    function automatic logic [N_DIGITS-1:0] sel_pol(input logic [N_DIGITS-1:0] v);
        return N_DIGITS'(apply_pol(16'(v), ACT_LOW != 0));
    endfunction

    function automatic logic [7:0] seg_pol(input logic [7:0] v);
        return 8'(apply_pol(16'(v), ACT_LOW != 0));
    endfunction

    // Limit re-evaluated every cycle; a shrinking limit below idx forces a wrap.
    assign lim     = (num > LAST_IDX) ? LAST_IDX : num;
    assign nxt     = (idx < lim) ? idx + 1'b1 : '0;
    assign nxt_pat = digit_data[{nxt, 3'b000} +: 8];
    assign adv     = tc && ((state == GAP) || (state == SHOW && BLANK == 0));

    assign cnt_clr = !en || (state == IDLE);
    assign term    = (state == GAP) ? GAP_TERM : SHOW_TERM;

    scan_tick_cnt #(
        .W(TICK_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .load   (tc),
        .ld_val ('0),
        .term   (term),
        .cnt    (tick),
        .tc     (tc)
    );

    // seg_out doubles as the pattern latch: written only on SHOW entry, so
    // digit_data changes during a dwell are not seen until the next visit.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            state      <= IDLE;
            idx        <= '0;
            sel_out    <= sel_pol('0);
            seg_out    <= seg_pol('0);
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                state   <= SHOW;
                idx     <= '0;
                sel_out <= sel_pol(N_DIGITS'(1));
                seg_out <= seg_pol(digit_data[7:0]);
            end else if (adv) begin
                state      <= SHOW;
                idx        <= nxt;
                sel_out    <= sel_pol(N_DIGITS'(1) << nxt);
                seg_out    <= seg_pol(nxt_pat);
                frame_done <= (nxt == '0);
            end else if (state == SHOW && tc) begin
                state   <= GAP;
                sel_out <= sel_pol('0);
                seg_out <= seg_pol('0);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: default build plus a BLANK=0 build.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  num = 3'd3;
    logic [63:0] digit_data = 64'h8877665544332211;
    logic [7:0]  sel0, seg0, sel1, seg1;
    logic        fd0, fd1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic [2:0] num;
        logic [7:0] sel;
        logic [7:0] seg;
        logic       fd;
    } vec_t;

    vec_t vec[$];

    always #5 clk = ~clk;

    seg_scan_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .num(num), .digit_data(digit_data),
        .sel_out(sel0), .seg_out(seg0), .frame_done(fd0)
    );

    seg_scan_ctrl #(.BLANK(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .num(num), .digit_data(digit_data),
        .sel_out(sel1), .seg_out(seg1), .frame_done(fd1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] asel, input logic [7:0] aseg,
                       input logic afd, input logic [7:0] esel, input logic [7:0] eseg,
                       input logic efd);
        n_chk++;
        if (asel !== esel || aseg !== eseg || afd !== efd) begin
            n_fail++;
            $display("FAIL %s: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                     nm, asel, aseg, afd, esel, eseg, efd);
        end
    endtask

    task automatic add(input logic e, input logic [2:0] n, input logic [7:0] s,
                       input logic [7:0] g, input logic f);
        vec_t v;
        v.en = e; v.num = n; v.sel = s; v.seg = g; v.fd = f;
        vec.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] sel_d [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [7:0] seg_d [4] = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};

    initial begin
        // Reset with en high: reset wins, everything inactive.
        en = 1'b1;
        rst_n = 1'b0;
        step();
        chk("rst_u0", sel0, seg0, fd0, 8'hFF, 8'hFF, 1'b0);
        chk("rst_u1", sel1, seg1, fd1, 8'hFF, 8'hFF, 1'b0);
        en = 1'b0;
        rst_n = 1'b1;

        // Table: two full num=3 frames, an en drop, then num=0 relighting.
        add(1'b0, 3'd3, 8'hFF, 8'hFF, 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                for (int t = 0; t < 4; t++)
                    add(1'b1, 3'd3, sel_d[d], seg_d[d], (f == 1 && d == 0 && t == 0));
                add(1'b1, 3'd3, 8'hFF, 8'hFF, 1'b0);
            end
        end
        add(1'b1, 3'd3, 8'hFE, 8'hEE, 1'b1);
        add(1'b0, 3'd0, 8'hFF, 8'hFF, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int t = 0; t < 4; t++)
                add(1'b1, 3'd0, 8'hFE, 8'hEE, (p > 0 && t == 0));
            add(1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0);
        end

        for (int i = 0; i < vec.size(); i++) begin
            en  = vec[i].en;
            num = vec[i].num;
            step();
            chk($sformatf("vec%0d", i), sel0, seg0, fd0, vec[i].sel, vec[i].seg, vec[i].fd);
        end

        // Limit drops from 7 to 2 while digit 5 is lit.
        en = 1'b0;
        do_reset();
        en = 1'b1; num = 3'd7;
        repeat (25) step();
        step();
        chk("n7_d5", sel0, seg0, fd0, 8'hDF, 8'h99, 1'b0);
        num = 3'd2;
        repeat (3) step();
        step();
        chk("drop_gap", sel0, seg0, fd0, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("drop_wrap", sel0, seg0, fd0, 8'hFE, 8'hEE, 1'b1);
        repeat (4) step();
        step();
        chk("drop_d1", sel0, seg0, fd0, 8'hFD, 8'hDD, 1'b0);
        repeat (4) step();
        step();
        chk("drop_d2", sel0, seg0, fd0, 8'hFB, 8'hCC, 1'b0);
        repeat (4) step();
        step();
        chk("drop_d0", sel0, seg0, fd0, 8'hFE, 8'hEE, 1'b1);

        // Pattern change mid-dwell is deferred to the next visit.
        en = 1'b0;
        do_reset();
        digit_data[7:0] = 8'h3F; num = 3'd0; en = 1'b1;
        step();
        chk("latch_t0", sel0, seg0, fd0, 8'hFE, 8'hC0, 1'b0);
        digit_data[7:0] = 8'h06;
        for (int t = 1; t < 4; t++) begin
            step();
            chk($sformatf("latch_t%0d", t), sel0, seg0, fd0, 8'hFE, 8'hC0, 1'b0);
        end
        step();
        chk("latch_gap", sel0, seg0, fd0, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("latch_new", sel0, seg0, fd0, 8'hFE, 8'hF9, 1'b1);
        digit_data[7:0] = 8'h11;

        // en dropped while digit 1 is lit, then restored.
        en = 1'b0;
        do_reset();
        num = 3'd3; en = 1'b1;
        repeat (7) step();
        chk("en_d1", sel0, seg0, fd0, 8'hFD, 8'hDD, 1'b0);
        en = 1'b0;
        step();
        chk("en_off", sel0, seg0, fd0, 8'hFF, 8'hFF, 1'b0);
        en = 1'b1;
        step();
        chk("en_restart", sel0, seg0, fd0, 8'hFE, 8'hEE, 1'b0);

        // Reset in GAP and mid-SHOW with en held high.
        en = 1'b0;
        do_reset();
        en = 1'b1;
        repeat (5) step();
        chk("gap_pre", sel0, seg0, fd0, 8'hFF, 8'hFF, 1'b0);
        rst_n = 1'b0;
        step();
        chk("gap_rst", sel0, seg0, fd0, 8'hFF, 8'hFF, 1'b0);
        rst_n = 1'b1;
        step();
        chk("gap_restart", sel0, seg0, fd0, 8'hFE, 8'hEE, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        chk("show_rst", sel0, seg0, fd0, 8'hFF, 8'hFF, 1'b0);
        rst_n = 1'b1;

        // BLANK=0 build: back-to-back digits, wrap pulse on return to digit 0.
        en = 1'b0;
        do_reset();
        num = 3'd3; en = 1'b1;
        for (int r = 0; r < 16; r++) begin
            step();
            chk($sformatf("nb%0d", r), sel1, seg1, fd1, sel_d[r/4], seg_d[r/4], 1'b0);
        end
        step();
        chk("nb_wrap", sel1, seg1, fd1, 8'hFE, 8'hEE, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
